// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter: the line FSM state
// encoding, default clock and baud rates, the data width, and the helper
// that turns a clock/baud pair into clock cycles per bit.
// No ports (package).
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_CLK_HZ_DEFAULT = 100_000_000;
  localparam int unsigned UART_BAUD_DEFAULT   = 115_200;
  localparam int unsigned UART_DATA_W         = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_state_t;

  // Integer division on purpose: the small residual baud error is absorbed
  // by sampling at mid-bit.
  function automatic int unsigned uart_cycles_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// ----------------------------------------------------------------------------
// uart_sync
// Two-flop synchroniser for a single asynchronous input. The reset value is a
// parameter so idle-high serial lines and idle-low switch inputs can share it.
// Ports:
//   clk      in  1  system clock
//   reset_n  in  1  asynchronous active-low reset
//   i_d      in  1  asynchronous input
//   o_q      out 1  input synchronised to clk
// ----------------------------------------------------------------------------
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver: 8 data bits, LSB first, no parity, 1 stop bit,
// line idle high. The line is synchronised, the start bit is validated at
// mid-bit, every data bit is sampled at mid-bit, and good bytes are presented
// through a one-entry holding register with a valid/ready handshake.
//
// State table
//   S_IDLE  | line idle, counters held at 0, waiting for a falling edge
//   S_START | half-bit wait, then confirm the start bit is still low
//   S_DATA  | sample 8 data bits, one per bit period
//   S_STOP  | sample the stop bit; deliver the byte or flag a framing error
//   S_BREAK | line held low after a framing error; wait for it to go high
//
// Ports:
//   clk        in  1  system clock, all state on its rising edge
//   reset_n    in  1  asynchronous active-low reset
//   rx         in  1  serial line, asynchronous to clk
//   data       out 8  received byte, meaningful while valid is high
//   valid      out 1  holding register full
//   ready      in  1  consumer accepts the byte when valid && ready
//   frame_err  out 1  one-cycle pulse: stop bit sampled low
//   overrun    out 1  one-cycle pulse: good byte dropped, holding reg full
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = UART_CLK_HZ_DEFAULT,
  parameter int unsigned BAUD   = UART_BAUD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int unsigned C  = uart_cycles_per_bit(CLK_HZ, BAUD);
  localparam int unsigned H  = C / 2;
  localparam int unsigned CW = $clog2(C);
  localparam int unsigned BW = $clog2(UART_DATA_W);

  localparam logic [CW-1:0] CNT_BIT  = CW'(C - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_W - 1);

  if (C < 4) begin : g_baud_check
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic                   w_rxs;
  uart_state_t            r_state;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rxs)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Consumption; a delivery later in this block overrides it.
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (!w_rxs) begin
            r_state <= S_START;
            r_cnt   <= CNT_HALF;
          end
        end

        S_START: begin
          if (r_cnt == '0) begin
            if (w_rxs) begin
              // Low pulse shorter than half a bit: treat as noise.
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_cnt     <= CNT_BIT;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_DATA: begin
          if (r_cnt == '0) begin
            // Right shift: the first (LSB) bit ends up at bit 0.
            r_shift <= {w_rxs, r_shift[UART_DATA_W-1:1]};
            r_cnt   <= CNT_BIT;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_STOP: begin
          if (r_cnt == '0) begin
            if (w_rxs) begin
              // Re-arm at mid-stop so a back-to-back start edge is not missed.
              r_state <= S_IDLE;
              if (!r_valid || ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_BREAK: begin
          // A held-low line must not be read as a stream of new start bits.
          if (w_rxs) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx at default parameters. The stimulus pushes the
// bytes it expects to be delivered; a negedge monitor pops and compares on
// every valid && ready transfer and also records valid rising edges and
// frame_err / overrun pulse cycles.
// ----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C   = 100_000_000 / 115_200;   // 868
  localparam int H   = C / 2;                   // 434
  localparam int LAT = 2 + H + 9 * C + 1;       // 8249

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int last_fall_cyc = 0;
  logic prev_valid = 1'b0;

  logic [7:0] exp_q[$];
  int         rise_q[$];

  uart_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: scoreboard pop on transfer, plus event logging.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_n) begin
      if (valid && !prev_valid) rise_q.push_back(cyc);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte actual=0x%02h expected=none", data);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", 32'(data), 32'(e));
        end
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
    prev_valid = valid;
  end

  // Called at posedge+1; leaves at posedge+1 after exactly 10*C cycles.
  task automatic send_byte(input logic [7:0] b);
    last_fall_cyc = cyc;
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic [7:0] frame_f0;
    frame_f0 = 8'hF0;
    rx      = 1'b1;
    ready   = 1'b1;
    reset_n = 1'b0;
    wait_cyc(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    wait_cyc(3);

    // Single byte and latency
    rise_q.delete();
    exp_q.push_back(8'h55);
    send_byte(8'h55);
    f0 = last_fall_cyc;
    check("single_valid_count", 32'(rise_q.size()), 32'd1);
    if (rise_q.size() >= 1) check_range("single_latency", rise_q[0] - f0, LAT - 1, LAT + 1);
    check("single_frame_err", 32'(fe_cnt), 32'd0);
    check("single_overrun", 32'(ov_cnt), 32'd0);

    // Back-to-back
    rise_q.delete();
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_byte(8'hA3);
    send_byte(8'h0F);
    check("b2b_valid_count", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() == 2) check("b2b_gap", 32'(rise_q[1] - rise_q[0]), 32'(10 * C));

    // Start-bit glitch
    rise_q.delete();
    rx = 1'b0;
    wait_cyc(100);
    rx = 1'b1;
    wait_cyc(400);
    check("glitch_state_idle", 32'(dut.r_state), 32'(S_IDLE));
    check("glitch_no_valid", 32'(rise_q.size()), 32'd0);
    check("glitch_no_frame_err", 32'(fe_cnt), 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    check("glitch_follow_count", 32'(rise_q.size()), 32'd1);

    // Break
    rise_q.delete();
    rx = 1'b0;
    wait_cyc(20 * C);
    rx = 1'b1;
    wait_cyc(20);
    check("break_frame_err_once", 32'(fe_cnt), 32'd1);
    check("break_no_valid", 32'(rise_q.size()), 32'd0);
    check("break_state_idle", 32'(dut.r_state), 32'(S_IDLE));
    exp_q.push_back(8'h7E);
    send_byte(8'h7E);
    check("break_follow_count", 32'(rise_q.size()), 32'd1);
    check("break_follow_frame_err", 32'(fe_cnt), 32'd1);

    // Overrun
    ready = 1'b0;
    rise_q.delete();
    exp_q.push_back(8'h11);
    send_byte(8'h11);
    check("ovr_first_valid", 32'(valid), 32'd1);
    check("ovr_first_data", 32'(data), 32'h11);
    send_byte(8'h22);
    check("ovr_pulse", 32'(ov_cnt), 32'd1);
    check("ovr_hold_valid", 32'(valid), 32'd1);
    check("ovr_hold_data", 32'(data), 32'h11);
    check("ovr_valid_count", 32'(rise_q.size()), 32'd1);
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    check("ovr_drain_valid", 32'(valid), 32'd0);
    check("ovr_drain_data", 32'(data), 32'h11);
    check("ovr_sb_empty", 32'(exp_q.size()), 32'd0);
    ready = 1'b1;
    wait_cyc(2);

    // Reset partway through bit 4 of 0xF0
    rise_q.delete();
    rx = 1'b0;
    wait_cyc(C);
    for (int i = 0; i < 4; i++) begin
      rx = frame_f0[i];
      wait_cyc(C);
    end
    rx = frame_f0[4];
    wait_cyc(C / 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(10);
    check("mid_rst_no_valid", 32'(rise_q.size()), 32'd0);
    exp_q.push_back(8'h9B);
    send_byte(8'h9B);
    check("mid_rst_follow_count", 32'(rise_q.size()), 32'd1);
    check("final_frame_err_total", 32'(fe_cnt), 32'd1);
    check("final_overrun_total", 32'(ov_cnt), 32'd1);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
